cdda_ctrl: RTL and testbench

- Sequencer for the CD-DA sample FIFO.
- Fetches whole audio sectors from an upstream source with a valid/ready handshake and forwards them word by word as edge-style write strobes to the FIFO.
- Paces FIFO read strobes at the CD sample rate using a fractional accumulator.
- Sits between the CD sector source (drive emulation / memory bridge) and the CD-DA FIFO that feeds the audio mixer.

---
 rtl/cdda_ctrl.sv | 137 +++++++++++++
 tb/tb_cdda_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdda_ctrl.sv
`timescale 1ns/1ps
// cdda_ctrl: CD-DA sample FIFO sequencer.
// Fetches whole sectors from an upstream source and writes them word by word
// into the CD-DA FIFO as edge-style strobes. It also paces the FIFO read
// strobes at the sample rate using a fractional accumulator.
//
// Source handshake (valid/ready): a word transfers on every rising CLK edge
// where SRC_VALID & SRC_READY are both high. SRC_READY depends only on the
// FSM state, never on SRC_VALID. The source holds SRC_DATA stable while
// SRC_VALID is high and no transfer has happened yet.
module cdda_ctrl #(
  parameter int unsigned SYS_HZ       = 48000000,
  parameter int unsigned SAMPLE_HZ    = 44100,
  parameter int unsigned SECTOR_WORDS = 1176
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic        PLAY,
  output logic        SRC_REQ,
  input  logic        SRC_VALID,
  input  logic [15:0] SRC_DATA,
  output logic        SRC_READY,
  input  logic        FIFO_WRITE_READY,
  output logic        FIFO_WRITE,
  output logic [15:0] FIFO_DOUT,
  output logic        FIFO_READ,
  output logic        BUSY,
  output logic [15:0] SECTOR_CNT,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_XFER = 3'd2,
    S_WR   = 3'd3,
    S_GAP  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam int unsigned CW = $clog2(SECTOR_WORDS + 1);
  localparam logic [CW-1:0] LAST_WORD   = CW'(SECTOR_WORDS);
  localparam logic [32:0]   SAMPLE_STEP = 33'(SAMPLE_HZ);
  localparam logic [32:0]   SYS_LIMIT   = 33'(SYS_HZ);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] word_cnt;
  logic [15:0]   dout_q;
  logic [15:0]   sector_q;
  logic [31:0]   acc;
  logic [32:0]   acc_sum;
  logic          tick;
  logic          read_q;
  logic          handshake;

  assign handshake  = SRC_VALID & SRC_READY;
  assign FIFO_DOUT  = dout_q;
  assign SECTOR_CNT = sector_q;
  assign FIFO_READ  = read_q;
  assign dbg_state  = state;

  // State register.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) state <= S_IDLE;
    else         state <= state_next;
  end

  // Next-state and Moore outputs. Every word costs at least three cycles:
  // the handshake, the write strobe, and a gap that guarantees a fresh edge.
  always_comb begin
    state_next = state;
    SRC_REQ    = 1'b0;
    SRC_READY  = 1'b0;
    FIFO_WRITE = 1'b0;
    BUSY       = 1'b0;
    case (state)
      S_IDLE: begin
        if (PLAY && FIFO_WRITE_READY) state_next = S_REQ;
      end
      S_REQ, S_XFER: begin
        SRC_REQ   = 1'b1;
        SRC_READY = 1'b1;
        BUSY      = 1'b1;
        if (SRC_VALID) state_next = S_WR;
      end
      S_WR: begin
        SRC_REQ    = 1'b1;
        FIFO_WRITE = 1'b1;
        BUSY       = 1'b1;
        state_next = S_GAP;
      end
      S_GAP: begin
        SRC_REQ    = 1'b1;
        BUSY       = 1'b1;
        state_next = (word_cnt == LAST_WORD) ? S_DONE : S_XFER;
      end
      S_DONE: begin
        BUSY       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: FIFO_DOUT only moves on a handshake, so it stays put through
  // the strobe and the gap after it. The FIFO latches the R word late and
  // relies on this.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      dout_q   <= '0;
      word_cnt <= '0;
      sector_q <= '0;
    end else begin
      if (handshake)        dout_q   <= SRC_DATA;
      if (state == S_WR)    word_cnt <= word_cnt + 1'b1;
      else if (state == S_DONE) word_cnt <= '0;
      if (state == S_DONE)  sector_q <= sector_q + 16'd1;
    end
  end

  assign acc_sum = {1'b0, acc} + SAMPLE_STEP;
  assign tick    = (acc_sum >= SYS_LIMIT);

  // Read pacing: the accumulator always runs. PLAY only masks the pulse, so
  // resuming playback never produces catch-up reads.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      acc    <= '0;
      read_q <= 1'b0;
    end else begin
      acc    <= tick ? 32'(acc_sum - SYS_LIMIT) : acc_sum[31:0];
      read_q <= tick & PLAY;
    end
  end

endmodule

// File: tb/tb_cdda_ctrl.sv
`timescale 1ns/1ps
// tb_cdda_ctrl: randomized scoreboard bench for the CD-DA sequencer.
module tb_cdda_ctrl;

  localparam int unsigned SYS_HZ       = 1000;
  localparam int unsigned SAMPLE_HZ    = 300;
  localparam int unsigned SECTOR_WORDS = 4;

  logic        clk = 1'b0;
  logic        nreset;
  logic        play;
  logic        src_valid;
  logic [15:0] src_data;
  logic        fifo_write_ready;
  logic        src_req;
  logic        src_ready;
  logic        fifo_write;
  logic [15:0] fifo_dout;
  logic        fifo_read;
  logic        busy;
  logic [15:0] sector_cnt;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_sectors = 0;
  logic [15:0] exp_q[$];
  int wr_cyc[$];

  // Pacing reference: after n edges since reset, exactly floor(n*S/H)
  // sample ticks have happened; a read pulse follows each new tick if PLAY.
  longint k = 0;
  logic exp_read = 1'b0;

  cdda_ctrl #(
    .SYS_HZ(SYS_HZ), .SAMPLE_HZ(SAMPLE_HZ), .SECTOR_WORDS(SECTOR_WORDS)
  ) dut (
    .CLK(clk), .nRESET(nreset), .PLAY(play),
    .SRC_REQ(src_req), .SRC_VALID(src_valid), .SRC_DATA(src_data),
    .SRC_READY(src_ready), .FIFO_WRITE_READY(fifo_write_ready),
    .FIFO_WRITE(fifo_write), .FIFO_DOUT(fifo_dout), .FIFO_READ(fifo_read),
    .BUSY(busy), .SECTOR_CNT(sector_cnt), .dbg_state(dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference pacing model.
  initial forever begin
    @(posedge clk or negedge nreset);
    if (!nreset) begin
      k = 0;
      exp_read = 1'b0;
    end else begin
      k = k + 1;
      exp_read = (((k * SAMPLE_HZ) / SYS_HZ) != (((k - 1) * SAMPLE_HZ) / SYS_HZ))
                 && play;
    end
  end

  // Monitor: pops the scoreboard on every FIFO write and checks read pacing.
  initial begin : monitor
    logic prev_write = 1'b0;
    logic prev_read = 1'b0;
    logic stable_pending = 1'b0;
    logic [15:0] stable_word = '0;
    logic [15:0] w;
    forever begin
      @(negedge clk);
      cyc++;
      if (nreset) begin
        if (stable_pending) begin
          check("dout_hold", fifo_dout, stable_word);
          stable_pending = 1'b0;
        end
        if (fifo_write) begin
          check("write_gap", prev_write, 1'b0);
          check("sb_nonempty", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            check("fifo_dout", fifo_dout, w);
            stable_word = w;
            stable_pending = 1'b1;
            wr_cyc.push_back(cyc);
          end
        end
        check("fifo_read", fifo_read, exp_read);
        if (fifo_read) check("read_gap", prev_read, 1'b0);
        prev_write = fifo_write;
        prev_read = fifo_read;
      end else begin
        prev_write = 1'b0;
        prev_read = 1'b0;
        stable_pending = 1'b0;
      end
    end
  end

  // Source driver: offers one word, optionally idling first.
  task automatic send_word(input logic [15:0] d, input int stall,
                           input bit check_stall);
    int waited;
    int bad;
    bad = 0;
    src_valid = 1'b0;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      if (check_stall && s >= 2 && (!src_ready || !busy || fifo_write)) bad++;
    end
    if (check_stall) check("stall_hold", bad, 0);
    src_data = d;
    src_valid = 1'b1;
    waited = 0;
    while (!src_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("src_ready_timeout", src_ready, 1'b1);
    if (src_ready) begin
      exp_q.push_back(d);
      @(negedge clk);
    end
    src_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int waited;
    waited = 0;
    @(negedge clk);
    while (busy && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("idle_timeout", busy, 1'b0);
  endtask

  task automatic check_sectors();
    exp_sectors++;
    check("sector_cnt", sector_cnt, exp_sectors);
  endtask

  // Main sequence.
  initial begin
    int cnt;
    logic [15:0] words [4];
    nreset = 1'b0;
    play = 1'b0;
    src_valid = 1'b0;
    src_data = '0;
    fifo_write_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_src_req", src_req, 1'b0);
    check("rst_src_ready", src_ready, 1'b0);
    check("rst_fifo_write", fifo_write, 1'b0);
    check("rst_fifo_read", fifo_read, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_sector_cnt", sector_cnt, 16'd0);
    check("rst_fifo_dout", fifo_dout, 16'd0);
    check("rst_state", dbg_state, 3'd0);

    // Pacing: 20 cycles of play give floor(20*S/H) pulses.
    play = 1'b1;
    nreset = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (fifo_read) cnt++;
    end
    check("pacing_count", cnt, (20 * SAMPLE_HZ) / SYS_HZ);

    // Back-pressure: FIFO not ready keeps the source idle.
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (src_req) cnt++;
    end
    check("backpressure_req", cnt, 0);
    fifo_write_ready = 1'b1;
    cnt = 0;
    while (!src_req && cnt < 2) begin
      @(negedge clk);
      cnt++;
    end
    check("req_after_ready", src_req, 1'b1);

    // Single sector, source always valid: writes three cycles apart.
    words[0] = 16'h1111; words[1] = 16'h2222;
    words[2] = 16'h3333; words[3] = 16'h4444;
    wr_cyc.delete();
    for (int i = 0; i < 4; i++) send_word(words[i], 0, 1'b0);
    wait_idle();
    check_sectors();
    check("idle_state", dbg_state, 3'd0);
    check("write_count", wr_cyc.size(), 4);
    for (int i = 1; i < wr_cyc.size(); i++)
      check("write_spacing", wr_cyc[i] - wr_cyc[i-1], 3);

    // PLAY dropped mid-sector: the sector still completes, nothing new starts.
    send_word(16'($urandom), 0, 1'b0);
    send_word(16'($urandom), 0, 1'b0);
    play = 1'b0;
    send_word(16'($urandom), 0, 1'b0);
    send_word(16'($urandom), 0, 1'b0);
    wait_idle();
    check_sectors();
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (src_req) cnt++;
    end
    check("no_req_after_stop", cnt, 0);

    // Source stall mid-sector.
    play = 1'b1;
    send_word(16'($urandom), 0, 1'b0);
    send_word(16'($urandom), 50, 1'b1);
    send_word(16'($urandom), 0, 1'b0);
    send_word(16'($urandom), 0, 1'b0);
    wait_idle();
    check_sectors();

    // Random sectors with random stalls and PLAY toggling.
    for (int s = 0; s < 6; s++) begin
      play = 1'b1;
      for (int i = 0; i < SECTOR_WORDS; i++) begin
        send_word(16'($urandom), $urandom_range(0, 3), 1'b0);
        play = 1'($urandom_range(0, 1));
      end
      wait_idle();
      check_sectors();
    end

    // Asynchronous reset while the write strobe is high.
    play = 1'b1;
    send_word(16'($urandom), 0, 1'b0);
    #2;
    nreset = 1'b0;
    #1;
    check("arst_fifo_write", fifo_write, 1'b0);
    check("arst_src_req", src_req, 1'b0);
    check("arst_src_ready", src_ready, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_sector_cnt", sector_cnt, 16'd0);
    exp_q.delete();
    exp_sectors = 0;
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    for (int i = 0; i < SECTOR_WORDS; i++) send_word(16'($urandom), 0, 1'b0);
    wait_idle();
    check_sectors();

    play = 1'b0;
    repeat (10) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
